// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a word-addressed register array; one outstanding burst per direction.
// Optional start-address range check enabled by defining AXI_SRAM_RANGE_CHECK_EN.
module axi4_sram_slave #(
  parameter int unsigned DW        = 64,
  parameter int unsigned AW        = 18,
  parameter int unsigned IDW       = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IDW-1:0]  MEM_AWID,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  output logic [IDW-1:0]  MEM_BID,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  input  logic [IDW-1:0]  MEM_ARID,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  output logic [IDW-1:0]  MEM_RID,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OFS   = $clog2(NB);
  localparam int unsigned ABITS = AW + OFS;
`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DW-1:0] ram [0:(2**AW)-1];

  w_state_t      w_state;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [1:0]    w_burst;
  logic          w_err;

  r_state_t      r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [1:0]    r_burst;
  logic          r_err;

  logic unused_size;
  assign unused_size = ^{MEM_AWSIZE, MEM_ARSIZE};

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return addr[ABITS-1:OFS];
  endfunction

  function automatic logic out_of_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return RANGE_CHECK && ((off >> ABITS) != 32'd0);
  endfunction

  // WRAP assumes len+1 is a power of two, so len doubles as the wrap mask.
  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                             input logic [7:0] len,
                                             input logic [1:0] burst);
    logic [AW-1:0] mask;
    mask = AW'(len);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | ((idx + AW'(1)) & mask);
      default: return idx + AW'(1);
    endcase
  endfunction

  // Write channel FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state     <= W_IDLE;
      MEM_AWREADY <= 1'b0;
      MEM_WREADY  <= 1'b0;
      MEM_BVALID  <= 1'b0;
      MEM_BRESP   <= 2'b00;
      MEM_BID     <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          MEM_AWREADY <= 1'b1;
          if (MEM_AWVALID && MEM_AWREADY) begin
            MEM_AWREADY <= 1'b0;
            MEM_WREADY  <= 1'b1;
            MEM_BID     <= MEM_AWID;
            w_idx       <= word_idx(MEM_AWADDR);
            w_len       <= MEM_AWLEN;
            w_burst     <= MEM_AWBURST;
            w_err       <= out_of_range(MEM_AWADDR);
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (MEM_WVALID && MEM_WREADY) begin
            w_idx <= next_idx(w_idx, w_len, w_burst);
            if (MEM_WLAST) begin
              MEM_WREADY <= 1'b0;
              MEM_BVALID <= 1'b1;
              MEM_BRESP  <= w_err ? 2'b10 : 2'b00;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (MEM_BREADY) begin
            MEM_BVALID  <= 1'b0;
            MEM_AWREADY <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array is never reset so preloaded and already-written contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && w_state == W_DATA && MEM_WVALID && MEM_WREADY && !w_err) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (MEM_WSTRB[b]) ram[w_idx][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
      end
    end
  end

  // Read channel FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= R_IDLE;
      MEM_ARREADY <= 1'b0;
      MEM_RVALID  <= 1'b0;
      MEM_RLAST   <= 1'b0;
      MEM_RRESP   <= 2'b00;
      MEM_RID     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          MEM_ARREADY <= 1'b1;
          if (MEM_ARVALID && MEM_ARREADY) begin
            MEM_ARREADY <= 1'b0;
            MEM_RVALID  <= 1'b1;
            MEM_RLAST   <= (MEM_ARLEN == 8'd0);
            MEM_RID     <= MEM_ARID;
            MEM_RRESP   <= out_of_range(MEM_ARADDR) ? 2'b10 : 2'b00;
            r_err       <= out_of_range(MEM_ARADDR);
            r_idx       <= word_idx(MEM_ARADDR);
            r_len       <= MEM_ARLEN;
            r_burst     <= MEM_ARBURST;
            r_cnt       <= 8'd0;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (MEM_RREADY) begin
            if (MEM_RLAST) begin
              MEM_RVALID  <= 1'b0;
              MEM_RLAST   <= 1'b0;
              MEM_ARREADY <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_idx     <= next_idx(r_idx, r_len, r_burst);
              r_cnt     <= r_cnt + 8'd1;
              MEM_RLAST <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
      endcase
    end
  end

  // Combinational array read: a same-cycle write becomes visible next cycle.
  assign MEM_RDATA = r_err ? '0 : ram[r_idx];

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed self-checking bench for axi4_sram_slave (default 64-bit data, 18-bit word address).
// Build with AXI_SRAM_RANGE_CHECK_EN defined to exercise the out-of-range responses.
module tb_axi4_sram_slave;

  logic        clk, rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;
  logic        rlast, rvalid, rready;

  int tests = 0;
  int fails = 0;

  axi4_sram_slave dut (
    .CLK(clk), .RST(rst),
    .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
    .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid), .MEM_AWREADY(awready),
    .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast), .MEM_WVALID(wvalid),
    .MEM_WREADY(wready),
    .MEM_BID(bid), .MEM_BRESP(bresp), .MEM_BVALID(bvalid), .MEM_BREADY(bready),
    .MEM_ARID(arid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen), .MEM_ARSIZE(arsize),
    .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid), .MEM_ARREADY(arready),
    .MEM_RID(rid), .MEM_RDATA(rdata), .MEM_RRESP(rresp), .MEM_RLAST(rlast),
    .MEM_RVALID(rvalid), .MEM_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("aw_handshake", 64'(awready), 64'(1));
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    chk("w_handshake", 64'(wready), 64'(1));
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    chk("bvalid_after_last", 64'(bvalid), 64'(1));
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(resp));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clear", 64'(bvalid), 64'(0));
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_handshake", 64'(arready), 64'(1));
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic rd_beat(input logic [63:0] data, input logic last, input logic [3:0] id,
                         input logic [1:0] resp, input logic stall);
    if (stall) begin
      rready = 1'b0;
      chk("rdata_pre_stall", rdata, data);
      @(negedge clk);
    end
    chk("rvalid", 64'(rvalid), 64'(1));
    chk("rdata", rdata, data);
    chk("rlast", 64'(rlast), 64'(last));
    chk("rid", 64'(rid), 64'(id));
    chk("rresp", 64'(rresp), 64'(resp));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rlast", 64'(rlast), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'(1));
    chk("post_rst_arready", 64'(arready), 64'(1));

    // Single write then read
    send_aw(4'd3, 32'h8000_0008, 8'd0, 2'b01);
    send_w(64'h1122334455667788, 8'hFF, 1'b1);
    get_b(4'd3, 2'b00);
    send_ar(4'd5, 32'h8000_0008, 8'd0, 2'b01);
    rd_beat(64'h1122334455667788, 1'b1, 4'd5, 2'b00, 1'b0);
    chk("rvalid_done_single", 64'(rvalid), 64'(0));

    // Partial strobe on a preloaded word
    dut.ram[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    send_aw(4'd1, 32'h8000_0000, 8'd0, 2'b01);
    send_w(64'h0, 8'h0F, 1'b1);
    get_b(4'd1, 2'b00);
    send_ar(4'd1, 32'h8000_0000, 8'd0, 2'b01);
    rd_beat(64'hFFFF_FFFF_0000_0000, 1'b1, 4'd1, 2'b00, 1'b0);

    // INCR burst of four, read back with a stall before every beat
    send_aw(4'd2, 32'h8000_0000, 8'd3, 2'b01);
    send_w(64'd1, 8'hFF, 1'b0);
    send_w(64'd2, 8'hFF, 1'b0);
    send_w(64'd3, 8'hFF, 1'b0);
    send_w(64'd4, 8'hFF, 1'b1);
    get_b(4'd2, 2'b00);
    send_ar(4'd6, 32'h8000_0000, 8'd3, 2'b01);
    rd_beat(64'd1, 1'b0, 4'd6, 2'b00, 1'b1);
    rd_beat(64'd2, 1'b0, 4'd6, 2'b00, 1'b1);
    rd_beat(64'd3, 1'b0, 4'd6, 2'b00, 1'b1);
    rd_beat(64'd4, 1'b1, 4'd6, 2'b00, 1'b1);
    chk("rvalid_done_incr", 64'(rvalid), 64'(0));

    // Two-beat WRAP write from word 1 lands on words 1 then 0
    send_aw(4'd4, 32'h8000_0008, 8'd1, 2'b10);
    send_w(64'hAA, 8'hFF, 1'b0);
    send_w(64'hBB, 8'hFF, 1'b1);
    get_b(4'd4, 2'b00);
    send_ar(4'd4, 32'h8000_0000, 8'd1, 2'b01);
    rd_beat(64'hBB, 1'b0, 4'd4, 2'b00, 1'b0);
    rd_beat(64'hAA, 1'b1, 4'd4, 2'b00, 1'b0);

    // WRAP and FIXED reads over a preloaded pattern
    for (int i = 0; i < 8; i++) dut.ram[i] = 64'hA0 + 64'(i);
    send_ar(4'd7, 32'h8000_0010, 8'd3, 2'b10);
    rd_beat(64'hA2, 1'b0, 4'd7, 2'b00, 1'b0);
    rd_beat(64'hA3, 1'b0, 4'd7, 2'b00, 1'b0);
    rd_beat(64'hA0, 1'b0, 4'd7, 2'b00, 1'b0);
    rd_beat(64'hA1, 1'b1, 4'd7, 2'b00, 1'b0);
    send_ar(4'd8, 32'h8000_0028, 8'd2, 2'b00);
    rd_beat(64'hA5, 1'b0, 4'd8, 2'b00, 1'b0);
    rd_beat(64'hA5, 1'b0, 4'd8, 2'b00, 1'b0);
    rd_beat(64'hA5, 1'b1, 4'd8, 2'b00, 1'b0);

    // Write to the word a pending read beat is showing
    send_ar(4'd9, 32'h8000_0030, 8'd0, 2'b01);
    chk("rw_before", rdata, 64'hA6);
    send_aw(4'd10, 32'h8000_0030, 8'd0, 2'b01);
    wdata = 64'h6666_0000_6666_0000; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    chk("rw_write_cycle_old", rdata, 64'hA6);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("rw_next_cycle_new", rdata, 64'h6666_0000_6666_0000);
    get_b(4'd10, 2'b00);
    rd_beat(64'h6666_0000_6666_0000, 1'b1, 4'd9, 2'b00, 1'b0);

    // Address above the array window
    send_aw(4'd11, 32'h9000_0000, 8'd0, 2'b01);
    send_w(64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    get_b(4'd11, 2'b10);
    chk("range_ram_untouched", dut.ram[0], 64'hA0);
    send_ar(4'd12, 32'h9000_0000, 8'd1, 2'b01);
    rd_beat(64'h0, 1'b0, 4'd12, 2'b10, 1'b0);
    rd_beat(64'h0, 1'b1, 4'd12, 2'b10, 1'b0);
`else
    get_b(4'd11, 2'b00);
    chk("alias_ram0", dut.ram[0], 64'hDEAD_BEEF_0BAD_F00D);
    send_ar(4'd12, 32'h9000_0000, 8'd1, 2'b01);
    rd_beat(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 4'd12, 2'b00, 1'b0);
    rd_beat(64'hA1, 1'b1, 4'd12, 2'b00, 1'b0);
`endif
    chk("rvalid_done_final", 64'(rvalid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 full slave wrapping a single-port-per-direction word-addressed SRAM array. Sits on the core's memory AXI port as main simulation memory.
- Read and write channels are independent; each supports one outstanding burst.
- The storage array is a plain register array named `ram` (depth 2^AW, width DW) so a testbench can preload it hierarchically.

Parameters:
- DW, 64, data width in bits (power of two, ≥32); byte lanes = DW/8; OFS = log2(DW/8).
- AW, 18, word-address width; array depth 2^AW words.
- IDW, 4, AXI ID width.
- BASE_ADDR, 32'h8000_0000, base byte address (used only with range check).

Ports:
- CLK in 1: clock, all logic on rising edge.
- RST in 1: synchronous active-high reset.
- MEM_AWID / MEM_ARID in IDW: request IDs.
- MEM_BID / MEM_RID out IDW: response IDs.
- MEM_AWADDR / MEM_ARADDR in 32: byte addresses.
- MEM_AWLEN / MEM_ARLEN in 8: beats−1.
- MEM_AWSIZE / MEM_ARSIZE in 3: accepted, ignored.
- MEM_AWBURST / MEM_ARBURST in 2: burst type.
- MEM_AWVALID / MEM_ARVALID in 1; MEM_AWREADY / MEM_ARREADY out 1: address handshakes.
- MEM_WDATA in DW; MEM_WSTRB in DW/8; MEM_WLAST in 1; MEM_WVALID in 1; MEM_WREADY out 1: write data channel.
- MEM_BRESP out 2; MEM_BVALID out 1; MEM_BREADY in 1: write response channel.
- MEM_RDATA out DW; MEM_RRESP out 2; MEM_RLAST out 1; MEM_RVALID out 1; MEM_RREADY in 1: read data channel.

Behaviour:
- Reset (RST=1 at edge):
  - Both FSMs go to IDLE.
  - AWREADY, ARREADY, WREADY, BVALID, RVALID and RLAST all 0.
  - BRESP and RRESP = 0; BID and RID = 0.
  - Array contents are NOT reset.
  - Reset mid-burst abandons the burst; already-written beats persist.
- Word index = ADDR[AW+OFS-1:OFS]. Upper bits are ignored (aliasing) unless the optional feature is on.
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID, word index, AWLEN and AWBURST; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes byte lane b of ram[idx] iff WSTRB[b]=1.
  - Index advances by 1 per beat for INCR (01) and WRAP (10, wraps within an aligned block of AWLEN+1 words). FIXED (00) holds the index. Reserved (11) is treated as INCR.
  - Burst ends on the beat with WLAST=1; go to W_RESP. Beat count is not checked against AWLEN.
  - W_RESP: BVALID=1, BID = latched ID, BRESP=2'b00. On BREADY, go to W_IDLE.
  - Minimum write latency: AW handshake, ≥1 cycle later first W beat, B valid the cycle after the last W beat.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: ARREADY=1. On handshake, latch ARID, index, ARLEN and ARBURST; beat counter = 0.
  - R_DATA: RVALID=1, RID = latched ID, RRESP=00, RDATA = ram[current idx] (combinational read of the array), RLAST = (counter==ARLEN).
  - On RVALID&RREADY: advance index per the same burst rules and increment the counter. If RLAST, return to R_IDLE.
  - RVALID/RDATA stay stable while RREADY=0.
- First read beat is valid the cycle after the AR handshake.
- Simultaneous read and write to the same word: the read beat in the write cycle shows old data; the new data is visible the following cycle.
- AW and AR may be accepted in the same cycle; the channels do not interact.

Optional Feature:
- Macro AXI_SRAM_RANGE_CHECK_EN.
- Defined: a burst whose start address satisfies (ADDR−BASE_ADDR) ≥ 2^(AW+OFS) is out of range:
  - Writes are suppressed for the whole burst and BRESP=2'b10 (SLVERR).
  - Reads return RDATA=0 and RRESP=2'b10 on every beat.
  - Handshakes and timing are unchanged.
- Undefined: no check; upper address bits ignored; all responses OKAY.

Test Plan:
- Reset: hold RST 3 cycles → AWREADY=ARREADY=0, BVALID=RVALID=0; cycle after release, AWREADY=ARREADY=1.
- Single write then read: AW addr 0x8000_0008 ID 3 LEN 0, W data 0x1122334455667788 STRB FF LAST → BVALID with BID=3, BRESP=0; AR same addr ID 5 → RDATA 0x1122334455667788, RID=5, RLAST=1.
- Partial strobe: preload ram[0]=0xFFFF…FF; write 0 with STRB 0x0F → read ram[0]=0xFFFFFFFF00000000.
- INCR burst: AW addr 0x8000_0000 LEN 3, data 1,2,3,4 → ram[0..3]=1..4; AR LEN 3 with RREADY toggled every other cycle → RDATA 1,2,3,4 in order, stable during stalls, RLAST only on 4th beat.
- WRAP burst: AR addr word 2 LEN 3 WRAP → beats read ram[2],ram[3],ram[0],ram[1]; FIXED LEN 2 at word 5 → ram[5] three times.
- With AXI_SRAM_RANGE_CHECK_EN: write to 0x9000_0000 → BRESP=2, array unchanged; read there → RRESP=2, RDATA=0.
